// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives an external N_IN-input gate through every input
// pattern, holds each pattern for DIV cycles, samples the gate response on the
// last cycle of the hold and compares it with the logic function chosen by
// mode. It reports a saturating mismatch count, the first failing pattern and
// a pass/done status.
module gate_sweep_checker #(
    parameter int N_IN  = 2,
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_valid
);

    localparam int HOLD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [N_IN-1:0]   PAT_LAST  = '1;
    localparam logic [N_IN-1:0]   PAT_ONE   = N_IN'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [2:0]         r_mode;
    logic               r_mode_legal;
    logic [N_IN-1:0]    r_pattern;
    logic [HOLD_W-1:0]  r_hold;
    logic [N_IN-1:0]    r_dut_in;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [CNT_W-1:0]   r_err_count;
    logic [N_IN-1:0]    r_first_vec;
    logic               r_first_valid;

    logic               w_start_legal;
    logic               w_launch;
    logic               w_sample;
    logic               w_last_pattern;
    logic               w_expected;
    logic               w_mismatch;

    // Mode legality of the incoming request (6 and 7 are reserved).
    assign w_start_legal  = (mode <= 3'd5);
    assign w_last_pattern = (r_pattern == PAT_LAST);

    // State register; reset returns to IDLE and aborts any sweep at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE, so a busy sweep ignores it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_start_legal ? S_HOLD : S_FINISH;
                end
            end
            S_HOLD: begin
                if (w_sample && w_last_pattern) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode: launch/sample strobes and the expected gate response.
    always_comb begin
        w_launch   = (r_state == S_IDLE) && start;
        w_sample   = (r_state == S_HOLD) && (r_hold == HOLD_LAST);
        w_expected = 1'b0;
        case (r_mode)
            3'd0:    w_expected = ~(|r_pattern);
            3'd1:    w_expected = ~(&r_pattern);
            3'd2:    w_expected = &r_pattern;
            3'd3:    w_expected = |r_pattern;
            3'd4:    w_expected = ^r_pattern;
            3'd5:    w_expected = ~(^r_pattern);
            default: w_expected = 1'b0;
        endcase
        w_mismatch = w_sample && (dut_out != w_expected);
    end

    // Sweep datapath: stimulus sequencing, hold timing and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= 3'd0;
            r_mode_legal  <= 1'b0;
            r_pattern     <= '0;
            r_hold        <= '0;
            r_dut_in      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_count   <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
        end else if (w_launch) begin
            // An illegal mode goes straight to FINISH with no stimulus and busy low.
            r_mode        <= mode;
            r_mode_legal  <= w_start_legal;
            r_pattern     <= '0;
            r_hold        <= '0;
            r_dut_in      <= '0;
            r_busy        <= w_start_legal;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_count   <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_done <= 1'b0;
                    if (w_sample) begin
                        if (w_mismatch) begin
                            if (r_err_count != CNT_MAX) begin
                                r_err_count <= r_err_count + CNT_ONE;
                            end
                            if (!r_first_valid) begin
                                r_first_vec   <= r_pattern;
                                r_first_valid <= 1'b1;
                            end
                        end
                        if (w_last_pattern) begin
                            r_dut_in <= '0;
                        end else begin
                            r_pattern <= r_pattern + PAT_ONE;
                            r_dut_in  <= r_pattern + PAT_ONE;
                            r_hold    <= '0;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_ONE;
                    end
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_pass <= (r_err_count == '0) && r_mode_legal;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in          = r_dut_in;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_vec   = r_first_vec;
    assign first_err_valid = r_first_valid;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a 2-input/DIV=4 instance against a
// modelled NOR gate, and a 3-input/DIV=2/CNT_W=2 instance with a stuck output.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // Instance A: N_IN=2, DIV=4, CNT_W=16
    logic        start_a;
    logic [2:0]  mode_a;
    logic [1:0]  dut_in_a;
    logic        dut_out_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] err_a;
    logic [1:0]  fev_a;
    logic        fval_a;
    int          model_a;   // 0: ideal NOR gate, 1: output stuck at 0

    assign dut_out_a = (model_a == 0) ? ~(|dut_in_a) : 1'b0;

    // Instance B: N_IN=3, DIV=2, CNT_W=2, gate output tied low
    logic        start_b;
    logic [2:0]  mode_b;
    logic [2:0]  dut_in_b;
    logic        dut_out_b;
    logic        busy_b, done_b, pass_b;
    logic [1:0]  err_b;
    logic [2:0]  fev_b;
    logic        fval_b;

    assign dut_out_b = 1'b0;

    gate_sweep_checker #(.N_IN(2), .DIV(4), .CNT_W(16)) u_dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start_a),
        .mode            (mode_a),
        .dut_in          (dut_in_a),
        .dut_out         (dut_out_a),
        .busy            (busy_a),
        .done            (done_a),
        .pass            (pass_a),
        .err_count       (err_a),
        .first_err_vec   (fev_a),
        .first_err_valid (fval_a)
    );

    gate_sweep_checker #(.N_IN(3), .DIV(2), .CNT_W(2)) u_dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start_b),
        .mode            (mode_b),
        .dut_in          (dut_in_b),
        .dut_out         (dut_out_b),
        .busy            (busy_b),
        .done            (done_b),
        .pass            (pass_b),
        .err_count       (err_b),
        .first_err_vec   (fev_b),
        .first_err_valid (fval_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge and count edges until done is seen (bounded).
    task automatic launch_and_wait(input bit use_b, input logic [2:0] m, output int lat);
        @(negedge clk);
        if (use_b) begin
            start_b = 1'b1;
            mode_b  = m;
        end else begin
            start_a = 1'b1;
            mode_a  = m;
        end
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if ((use_b ? done_b : done_a) === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        mode_a  = 3'd0;
        start_b = 1'b0;
        mode_b  = 3'd0;
        model_a = 0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_dut_in", {30'd0, dut_in_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_pass", {31'd0, pass_a}, 32'd0);
        chk("rst_err", {16'd0, err_a}, 32'd0);
        chk("rst_fval", {31'd0, fval_a}, 32'd0);
        rst_n = 1'b1;

        // ---- sweep 1: NOR against ideal NOR, cycle-exact stimulus ----
        @(negedge clk);
        start_a = 1'b1;
        mode_a  = 3'd0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            start_a = 1'b0;
            chk($sformatf("s1_dut_in_c%0d", j), {30'd0, dut_in_a}, j / 4);
            chk($sformatf("s1_busy_c%0d", j), {31'd0, busy_a}, 32'd1);
            chk($sformatf("s1_done_c%0d", j), {31'd0, done_a}, 32'd0);
        end
        @(negedge clk);   // after edge k+16: FINISH
        chk("s1_finish_done", {31'd0, done_a}, 32'd0);
        chk("s1_finish_busy", {31'd0, busy_a}, 32'd1);
        @(negedge clk);   // after edge k+17: done pulse
        chk("s1_done", {31'd0, done_a}, 32'd1);
        chk("s1_busy_off", {31'd0, busy_a}, 32'd0);
        chk("s1_pass", {31'd0, pass_a}, 32'd1);
        chk("s1_err", {16'd0, err_a}, 32'd0);
        chk("s1_fval", {31'd0, fval_a}, 32'd0);
        chk("s1_dut_in_end", {30'd0, dut_in_a}, 32'd0);
        @(negedge clk);
        chk("s1_done_pulse_end", {31'd0, done_a}, 32'd0);
        chk("s1_pass_held", {31'd0, pass_a}, 32'd1);
        $display("sweep1 mode=0 model=nor err=%0d pass=%0d", err_a, pass_a);

        // ---- sweep 2: NOR with output stuck at 0 ----
        model_a = 1;
        launch_and_wait(1'b0, 3'd0, lat);
        chk("s2_latency", lat, 32'd17);
        chk("s2_err", {16'd0, err_a}, 32'd1);
        chk("s2_fev", {30'd0, fev_a}, 32'd0);
        chk("s2_fval", {31'd0, fval_a}, 32'd1);
        chk("s2_pass", {31'd0, pass_a}, 32'd0);
        repeat (3) @(negedge clk);
        chk("s2_fval_held", {31'd0, fval_a}, 32'd1);
        chk("s2_err_held", {16'd0, err_a}, 32'd1);
        $display("sweep2 mode=0 model=stuck0 err=%0d fev=%0d pass=%0d", err_a, fev_a, pass_a);

        // ---- sweep 3: NAND expected against ideal NOR ----
        model_a = 0;
        launch_and_wait(1'b0, 3'd1, lat);
        chk("s3_latency", lat, 32'd17);
        chk("s3_err", {16'd0, err_a}, 32'd2);
        chk("s3_fev", {30'd0, fev_a}, 32'd1);
        chk("s3_fval", {31'd0, fval_a}, 32'd1);
        chk("s3_pass", {31'd0, pass_a}, 32'd0);
        $display("sweep3 mode=1 model=nor err=%0d fev=%0d pass=%0d", err_a, fev_a, pass_a);

        // ---- sweep 4: ignored restart, then reset at pattern 2 ----
        model_a = 1;
        @(negedge clk);
        start_a = 1'b1;
        mode_a  = 3'd0;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            if (j == 0) start_a = 1'b0;
            if (j == 6) begin
                start_a = 1'b0;
                chk("s4_no_restart_dut_in", {30'd0, dut_in_a}, 32'd1);
                chk("s4_no_restart_busy", {31'd0, busy_a}, 32'd1);
            end
            if (j == 5) start_a = 1'b1;
        end
        chk("s4_pre_rst_dut_in", {30'd0, dut_in_a}, 32'd2);
        chk("s4_pre_rst_err", {16'd0, err_a}, 32'd1);
        chk("s4_pre_rst_fval", {31'd0, fval_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s4_rst_dut_in", {30'd0, dut_in_a}, 32'd0);
        chk("s4_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("s4_rst_err", {16'd0, err_a}, 32'd0);
        chk("s4_rst_fval", {31'd0, fval_a}, 32'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("s4_rst_no_done_c%0d", j), {31'd0, done_a}, 32'd0);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk($sformatf("s4_idle_no_done_c%0d", j), {31'd0, done_a}, 32'd0);
        end
        model_a = 0;
        launch_and_wait(1'b0, 3'd0, lat);
        chk("s4_fresh_latency", lat, 32'd17);
        chk("s4_fresh_pass", {31'd0, pass_a}, 32'd1);
        chk("s4_fresh_err", {16'd0, err_a}, 32'd0);
        $display("sweep4 restart-after-reset err=%0d pass=%0d", err_a, pass_a);

        // ---- sweep 5: illegal mode 6 ----
        @(negedge clk);
        start_a = 1'b1;
        mode_a  = 3'd6;
        @(negedge clk);
        start_a = 1'b0;
        chk("s5_busy0", {31'd0, busy_a}, 32'd0);
        chk("s5_done0", {31'd0, done_a}, 32'd0);
        chk("s5_pass_cleared", {31'd0, pass_a}, 32'd0);
        @(negedge clk);
        chk("s5_done", {31'd0, done_a}, 32'd1);
        chk("s5_busy", {31'd0, busy_a}, 32'd0);
        chk("s5_pass", {31'd0, pass_a}, 32'd0);
        chk("s5_dut_in", {30'd0, dut_in_a}, 32'd0);
        @(negedge clk);
        chk("s5_done_end", {31'd0, done_a}, 32'd0);
        $display("sweep5 mode=6 pass=%0d busy=%0d", pass_a, busy_a);

        // ---- sweep 6: 3-input XOR, stuck output, 2-bit saturating counter ----
        launch_and_wait(1'b1, 3'd4, lat);
        chk("s6_latency", lat, 32'd17);
        chk("s6_err_sat", {30'd0, err_b}, 32'd3);
        chk("s6_fev", {29'd0, fev_b}, 32'd1);
        chk("s6_fval", {31'd0, fval_b}, 32'd1);
        chk("s6_pass", {31'd0, pass_b}, 32'd0);
        chk("s6_dut_in", {29'd0, dut_in_b}, 32'd0);
        $display("sweep6 n_in=3 mode=4 err=%0d fev=%0d pass=%0d", err_b, fev_b, pass_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Parametrised successor to the team's 2-input NOR cell with a clocked stimulus/check engine.
- Drives an external N-input gate with all 2^N_IN input patterns, holding each for a programmable number of cycles.
- Samples the gate output, compares it against the expected function selected by mode, and reports an error count, the first failing vector and pass/done status.
- Sits beside a switch-level gate instance as its on-chip self-check.

Parameters:
- N_IN, 2, number of gate inputs (legal 2..8).
- DIV, 4, clock cycles each pattern is held (legal 2..256). The last cycle of the hold is the sample cycle.
- CNT_W, 16, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin sweep; level sampled each edge, acted on only when not busy.
- mode  input  3  expected function, latched at start: 0 NOR, 1 NAND, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6/7 illegal.
- dut_in  output  N_IN  stimulus to the gate under test; bit 0 toggles fastest.
- dut_out  input  1  gate response; synchronous to clk.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  1 when the last sweep had zero mismatches and a legal mode; held until the next start.
- err_count  output  CNT_W  saturating mismatch count for the last or current sweep.
- first_err_vec  output  N_IN  pattern of the first mismatch.
- first_err_valid  output  1  first_err_vec is meaningful.

Behaviour:
- Reset values: every output 0, including dut_in, busy, done, pass, err_count, first_err_vec and first_err_valid. The FSM resets to IDLE.
- Reset mid-sweep aborts immediately, with no done pulse.
- FSM states are IDLE, HOLD, FINISH.
  - IDLE → HOLD: start=1 at edge k with legal mode. At that edge: latch mode, pattern←0, hold counter←0, dut_in←0, busy←1, clear err_count, first_err_valid and pass.
  - IDLE with illegal mode: at edge k go to FINISH with pass forced 0 and no stimulus.
  - HOLD: the hold counter counts 0..DIV-1. When the counter equals DIV-1, the edge samples dut_out and compares it against f(mode, pattern).
    - Mismatch: err_count+1, saturating at all-ones. If first_err_valid=0, capture first_err_vec←pattern and set first_err_valid.
    - If pattern = 2^N_IN-1, go to FINISH and dut_in←0. Otherwise pattern+1, dut_in←pattern+1, counter←0.
  - FINISH: one cycle. At the next edge: done←1 for exactly one cycle, busy←0, pass←(err_count==0 and mode legal), return to IDLE.
- Timing for a legal sweep started at edge k:
  - Pattern p is driven during cycles k+1+p·DIV through k+(p+1)·DIV.
  - Its sample edge is k+(p+1)·DIV.
  - done is high after edge k+2^N_IN·DIV+1, i.e. 2^N_IN·DIV+1 edges after start.
- Timing for an illegal mode started at edge k: done rises at edge k+1.
- start while busy is ignored, with no restart or state change.
- start held high across FINISH→IDLE launches a new sweep at the first IDLE edge.
- A new start clears pass, err_count and first-error data at the start edge.
- dut_in changes only at pattern boundaries, so it is glitch-free between boundaries.
- Expected function is computed over all N_IN bits: NOR = ~|v, NAND = ~&v, AND = &v, OR = |v, XOR = ^v, XNOR = ~^v.
- err_count never wraps.
- first_err_vec and first_err_valid hold their values after done until the next start.

Test Plan:
- N_IN=2, DIV=4, mode=0, ideal NOR model on dut_out, start pulse at edge k. Required response:
  - dut_in sequence 00,01,10,11, each held 4 cycles.
  - done after 17 edges, pass=1, err_count=0, first_err_valid=0.
- Same setup, dut_out stuck at 0 → err_count=1, first_err_vec=00, first_err_valid=1, pass=0.
- mode=1 (NAND) against the ideal NOR model → mismatches at 01 and 10; err_count=2, first_err_vec=01, pass=0.
- start asserted again mid-sweep, then rst_n pulsed low for 3 cycles at pattern 2. Required response:
  - The mid-sweep start is ignored.
  - Reset clears all outputs asynchronously, with no done pulse.
  - A fresh start afterwards completes a normal sweep.
- mode=6 → done one cycle after start, busy never high, pass=0, dut_in stays 0.
- N_IN=3, CNT_W=2, mode=4 (XOR) with dut_out tied to 0 → 4 mismatches; err_count saturates at 3, first_err_vec=001.
